// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states, ALU/command/op/cond codes,
// datapath select encodings and the condition-check helper.
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110;

    localparam logic       SRCA_REG   = 1'b0;
    localparam logic       SRCA_PC    = 1'b1;
    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // flags are packed {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition unit: NZCV register, condition evaluation against the held flags, gated flag writes.
module cond_unit
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    assign cond_ex = cond_eval(cond, flags_q);
    assign flags   = flags_q;

    // flag_w is only non-zero during execute, so the flags stay fixed for the rest of an instruction
    always_comb begin
        flags_d = flags_q;
        if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder and condition unit instance.
// Build option: define CONTROLLER_CMP_EN to decode CMP as a flags-only SUB.
module multicycle_controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl
);

    state_e     state_q, state_d;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_is_pc;
    logic       cond_ex;
    logic [3:0] flags_unused;
    logic       unused_rn;
    logic [1:0] dec_ctrl;
    logic [1:0] dec_flag_w;
    logic       no_write;
    logic       alu_exec;
    logic [1:0] flag_w;
    logic       pc_we, mem_we, reg_we, ir_we;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign unused_rn = ^Instr[7:4];
    assign rd_is_pc  = (Instr[3:0] == 4'hF);

    assign ImmSrc    = op;
    assign RegSrc    = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

    always_comb begin
        dec_ctrl   = ALU_ADD;
        dec_flag_w = 2'b00;
        no_write   = 1'b0;
        case (funct[4:1])
            CMD_ADD: begin dec_ctrl = ALU_ADD; dec_flag_w = {funct[0], funct[0]}; end
            CMD_SUB: begin dec_ctrl = ALU_SUB; dec_flag_w = {funct[0], funct[0]}; end
            CMD_AND: begin dec_ctrl = ALU_AND; dec_flag_w = {funct[0], 1'b0}; end
            CMD_ORR: begin dec_ctrl = ALU_ORR; dec_flag_w = {funct[0], 1'b0}; end
`ifdef CONTROLLER_CMP_EN
            CMD_CMP: begin dec_ctrl = ALU_SUB; dec_flag_w = 2'b11; no_write = 1'b1; end
`endif
            default: no_write = 1'b1;
        endcase
    end

    assign alu_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign flag_w   = alu_exec ? dec_flag_w : 2'b00;

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .cond_ex   (cond_ex),
        .flags     (flags_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        ir_we      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = alu_exec ? dec_ctrl : ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = cond_ex;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_we    = cond_ex;
                pc_we     = cond_ex & rd_is_pc;
            end
            S_EXECR:  ALUSrcB = SRCB_WD;
            S_EXECI:  ALUSrcB = SRCB_IMM;
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_we    = cond_ex & ~no_write;
                pc_we     = cond_ex & rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                pc_we     = cond_ex;
            end
            default: ;
        endcase
    end

    // the async reset puts the FSM in FETCH; enables are additionally masked while reset is held
    assign PCWrite  = pc_we  & reset;
    assign MemWrite = mem_we & reset;
    assign RegWrite = reg_we & reset;
    assign IRWrite  = ir_we  & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks dp/LDR/STR/B/CMP/undefined instructions and a mid-instruction reset.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    int compared = 0;
    int mismatched = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                       input logic [3:0] rd);
        return {c, o, f, 4'h0, rd};
    endfunction

    initial begin
        reset = 1'b0;
        Instr = 20'h0;
        ALUFlags = 4'h0;
        #1;
        $display("reset held low");
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_alusrcb", ALUSrcB, 2'b10);
        chk("rst_flags", dut.u_cond.flags_q, 4'b0000);
        @(negedge clk);
        @(negedge clk);

        // ADDS R1,R2,#0 with ALUFlags 0100
        reset = 1'b1;
        Instr = mk(4'hE, 2'b00, 6'b101001, 4'h1);
        ALUFlags = 4'b0100;
        #1;
        $display("ADDS R1,R2,#0");
        chk("adds_f_pcwrite", PCWrite, 1);
        chk("adds_f_irwrite", IRWrite, 1);
        chk("adds_f_resultsrc", ResultSrc, 2'b10);
        next_cyc();
        chk("adds_d_irwrite", IRWrite, 0);
        chk("adds_d_alusrca", ALUSrcA, 1);
        next_cyc();
        chk("adds_e_aluctl", ALUControl, 2'b00);
        chk("adds_e_alusrcb", ALUSrcB, 2'b01);
        chk("adds_e_flags_pre", dut.u_cond.flags_q, 4'b0000);
        next_cyc();
        chk("adds_wb_regwrite", RegWrite, 1);
        chk("adds_wb_pcwrite", PCWrite, 0);
        chk("adds_flags", dut.u_cond.flags_q, 4'b0100);
        next_cyc();
        chk("adds_4cyc_irwrite", IRWrite, 1);

        // SUBSNE R3,R3,R4 after Z=1: suppressed, flags untouched
        Instr = mk(4'h1, 2'b00, 6'b000101, 4'h3);
        ALUFlags = 4'b1111;
        #1;
        $display("SUBSNE R3,R3,R4");
        chk("subne_f_pcwrite", PCWrite, 1);
        next_cyc();
        next_cyc();
        chk("subne_e_aluctl", ALUControl, 2'b01);
        chk("subne_e_alusrcb", ALUSrcB, 2'b00);
        next_cyc();
        chk("subne_wb_regwrite", RegWrite, 0);
        chk("subne_flags", dut.u_cond.flags_q, 4'b0100);
        next_cyc();

        // LDR R15
        Instr = mk(4'hE, 2'b01, 6'b011001, 4'hF);
        #1;
        $display("LDR R15");
        next_cyc();
        next_cyc();
        chk("ldr_ma_alusrcb", ALUSrcB, 2'b01);
        chk("ldr_ma_immsrc", ImmSrc, 2'b01);
        chk("ldr_ma_regsrc", RegSrc, 2'b00);
        next_cyc();
        chk("ldr_mr_adrsrc", AdrSrc, 1);
        chk("ldr_mr_regwrite", RegWrite, 0);
        next_cyc();
        chk("ldr_wb_resultsrc", ResultSrc, 2'b01);
        chk("ldr_wb_regwrite", RegWrite, 1);
        chk("ldr_wb_pcwrite", PCWrite, 1);
        next_cyc();
        chk("ldr_5cyc_irwrite", IRWrite, 1);

        // BEQ taken (Z=1)
        Instr = mk(4'h0, 2'b10, 6'b100000, 4'h0);
        #1;
        $display("BEQ Z=1");
        next_cyc();
        next_cyc();
        chk("beq1_pcwrite", PCWrite, 1);
        chk("beq1_resultsrc", ResultSrc, 2'b10);
        chk("beq1_regsrc", RegSrc, 2'b01);
        next_cyc();
        chk("beq1_3cyc_irwrite", IRWrite, 1);

        // STR R2
        Instr = mk(4'hE, 2'b01, 6'b011000, 4'h2);
        #1;
        $display("STR R2");
        chk("str_regsrc", RegSrc, 2'b10);
        next_cyc();
        next_cyc();
        next_cyc();
        chk("str_mw_memwrite", MemWrite, 1);
        chk("str_mw_adrsrc", AdrSrc, 1);
        next_cyc();
        chk("str_4cyc_irwrite", IRWrite, 1);

        // ORRS with ALUFlags 1011: only NZ written
        Instr = mk(4'hE, 2'b00, 6'b111001, 4'h5);
        ALUFlags = 4'b1011;
        #1;
        $display("ORRS R5,#imm");
        next_cyc();
        next_cyc();
        chk("orrs_e_aluctl", ALUControl, 2'b11);
        next_cyc();
        chk("orrs_flags", dut.u_cond.flags_q, 4'b1000);
        next_cyc();

        // BEQ not taken (Z=0)
        Instr = mk(4'h0, 2'b10, 6'b100000, 4'h0);
        #1;
        $display("BEQ Z=0");
        next_cyc();
        next_cyc();
        chk("beq0_pcwrite", PCWrite, 0);
        next_cyc();

        // CMP R1,R2 (0xE15x)
        Instr = mk(4'hE, 2'b00, 6'b010101, 4'h0);
        ALUFlags = 4'b0110;
        #1;
        $display("CMP R1,R2");
        next_cyc();
        next_cyc();
`ifdef CONTROLLER_CMP_EN
        chk("cmp_e_aluctl", ALUControl, 2'b01);
`else
        chk("cmp_e_aluctl", ALUControl, 2'b00);
`endif
        next_cyc();
        chk("cmp_wb_regwrite", RegWrite, 0);
`ifdef CONTROLLER_CMP_EN
        chk("cmp_flags", dut.u_cond.flags_q, 4'b0110);
`else
        chk("cmp_flags", dut.u_cond.flags_q, 4'b1000);
`endif
        next_cyc();

        // undefined op 11: DECODE straight back to FETCH
        Instr = mk(4'hE, 2'b11, 6'b000000, 4'h0);
        #1;
        $display("op=11");
        next_cyc();
        next_cyc();
        chk("op11_back_fetch", IRWrite, 1);

        // ADDS with ALUFlags 1111, then LDR interrupted by reset in MEMRD
        Instr = mk(4'hE, 2'b00, 6'b101001, 4'h1);
        ALUFlags = 4'b1111;
        #1;
        $display("ADDS flags=1111 then LDR with reset in MEMRD");
        next_cyc();
        next_cyc();
        next_cyc();
        chk("adds2_flags", dut.u_cond.flags_q, 4'b1111);
        next_cyc();
        Instr = mk(4'hE, 2'b01, 6'b011001, 4'h2);
        next_cyc();
        next_cyc();
        next_cyc();
        chk("ldr2_mr_adrsrc", AdrSrc, 1);
        reset = 1'b0;
        #1;
        chk("midrst_flags", dut.u_cond.flags_q, 4'b0000);
        chk("midrst_adrsrc", AdrSrc, 0);
        chk("midrst_alusrcb", ALUSrcB, 2'b10);
        chk("midrst_wes", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        next_cyc();
        chk("midrst_hold_wes", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        reset = 1'b1;
        #1;
        chk("release_fetch_wes", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b1001);
        next_cyc();
        chk("release_decode_irwrite", IRWrite, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
